// File: rtl/mul_div_unit_pkg.sv
// Shared opcodes, FSM state type and small opcode decoders for the
// iterative multiply/divide unit.
package mul_div_unit_pkg;

   // Opcode encodings driven on mul_div_unit.op by the decode stage
   localparam logic [2:0] MDU_OP_MULT  = 3'd0;
   localparam logic [2:0] MDU_OP_MULTU = 3'd1;
   localparam logic [2:0] MDU_OP_DIV   = 3'd2;
   localparam logic [2:0] MDU_OP_DIVU  = 3'd3;
   localparam logic [2:0] MDU_OP_MTHI  = 3'd4;
   localparam logic [2:0] MDU_OP_MTLO  = 3'd5;

   // FSM states: IDLE accepts, MUL/DIV iterate, DONE issues the HI/LO write
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } mdu_state_e;

   // Ops that run through the multi-cycle datapath and stall EX
   function automatic logic is_iter_op(input logic [2:0] op);
      return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU) ||
             (op == MDU_OP_DIV)  || (op == MDU_OP_DIVU);
   endfunction

   // Ops whose operands are two's-complement and need sign handling
   function automatic logic is_signed_op(input logic [2:0] op);
      return (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
   endfunction

endpackage

// File: rtl/mul_div_unit_div_iter.sv
// Restoring-divide datapath: unsigned dividend/divisor, one quotient bit
// per enabled cycle. The next-step quotient/remainder are exported so the
// parent can capture the final result in the same cycle as the last step.
module mul_div_unit_div_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient_nxt,
   output logic [WIDTH-1:0] remainder_nxt
);

   // quo_q starts as the dividend and has quotient bits shifted in from the
   // bottom while dividend bits leave from the top into the remainder.
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH:0]   partial;
   logic [WIDTH:0]   diff;

   // One restoring step: trial subtract, keep it if no borrow
   always_comb begin
      partial = {rem_q, quo_q[WIDTH-1]};
      diff    = partial - {1'b0, dvs_q};
      if (!diff[WIDTH]) begin
         remainder_nxt = diff[WIDTH-1:0];
         quotient_nxt  = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
         remainder_nxt = partial[WIDTH-1:0];
         quotient_nxt  = {quo_q[WIDTH-2:0], 1'b0};
      end
   end

   // Load new operands or advance one step
   always_comb begin
      quo_d = quo_q;
      rem_d = rem_q;
      dvs_d = dvs_q;
      if (load) begin
         quo_d = dividend;
         rem_d = '0;
         dvs_d = divisor;
      end else if (en) begin
         quo_d = quotient_nxt;
         rem_d = remainder_nxt;
      end
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         quo_q <= '0;
         rem_q <= '0;
         dvs_q <= '0;
      end else begin
         quo_q <= quo_d;
         rem_q <= rem_d;
         dvs_q <= dvs_d;
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit for the EX stage. MULT/MULTU/DIV/DIVU take
// WIDTH iteration cycles plus one DONE cycle that writes HI and LO;
// MTHI/MTLO write on the cycle after acceptance without leaving IDLE.
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             stallreq,
   output logic             busy,
   output logic             hi_we,
   output logic             lo_we,
   output logic [WIDTH-1:0] hi_wdata,
   output logic [WIDTH-1:0] lo_wdata
);

   localparam int CW = $clog2(WIDTH);

   mdu_state_e         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic               neg_res_q, neg_res_d;
   logic               neg_rem_q, neg_rem_d;
   logic               dz_q, dz_d;
   logic               hi_we_q, hi_we_d;
   logic               lo_we_q, lo_we_d;
   logic [WIDTH-1:0]   hi_wdata_q, hi_wdata_d;
   logic [WIDTH-1:0]   lo_wdata_q, lo_wdata_d;

   logic               accept;
   logic               signed_op;
   logic               last_step;
   logic               div_load;
   logic               div_en;
   logic               kill_done;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next, mul_fixed;
   logic [WIDTH-1:0]   quo_nxt, rem_nxt;
   logic [WIDTH-1:0]   quo_fixed, rem_fixed;

   // Operand magnitudes, one multiply step and final sign correction
   always_comb begin
      accept    = (state_q == ST_IDLE) && start && !flush;
      signed_op = is_signed_op(op);
      abs_a     = (signed_op && src_a[WIDTH-1]) ? -src_a : src_a;
      abs_b     = (signed_op && src_b[WIDTH-1]) ? -src_b : src_b;
      last_step = (cnt_q == CW'(WIDTH-1));
      // acc holds {partial product, unconsumed multiplier bits}
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                  (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
      mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
      mul_fixed = neg_res_q ? -mul_next : mul_next;
      // Divide-by-zero leaves quotient all ones unfixed; the remainder is
      // |a| re-signed by a's sign, which reproduces src_a exactly.
      quo_fixed = dz_q ? {WIDTH{1'b1}} : (neg_res_q ? -quo_nxt : quo_nxt);
      rem_fixed = neg_rem_q ? -rem_nxt : rem_nxt;
   end

   // FSM next state, operand latching and result capture
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      mcand_d    = mcand_q;
      neg_res_d  = neg_res_q;
      neg_rem_d  = neg_rem_q;
      dz_d       = dz_q;
      hi_we_d    = 1'b0;
      lo_we_d    = 1'b0;
      hi_wdata_d = hi_wdata_q;
      lo_wdata_d = lo_wdata_q;
      div_load   = 1'b0;
      div_en     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               case (op)
                  MDU_OP_MTHI: begin
                     hi_we_d    = 1'b1;
                     hi_wdata_d = src_a;
                  end
                  MDU_OP_MTLO: begin
                     lo_we_d    = 1'b1;
                     lo_wdata_d = src_a;
                  end
                  MDU_OP_MULT, MDU_OP_MULTU: begin
                     state_d   = ST_MUL;
                     cnt_d     = '0;
                     acc_d     = {{WIDTH{1'b0}}, abs_b};
                     mcand_d   = abs_a;
                     neg_res_d = signed_op && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                     neg_rem_d = 1'b0;
                     dz_d      = 1'b0;
                  end
                  MDU_OP_DIV, MDU_OP_DIVU: begin
                     state_d   = ST_DIV;
                     cnt_d     = '0;
                     div_load  = 1'b1;
                     neg_res_d = signed_op && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                     neg_rem_d = signed_op && src_a[WIDTH-1];
                     dz_d      = (src_b == '0);
                  end
                  default: ;
               endcase
            end
         end
         ST_MUL: begin
            acc_d = mul_next;
            cnt_d = cnt_q + CW'(1);
            if (last_step) begin
               state_d    = ST_DONE;
               hi_we_d    = 1'b1;
               lo_we_d    = 1'b1;
               hi_wdata_d = mul_fixed[2*WIDTH-1:WIDTH];
               lo_wdata_d = mul_fixed[WIDTH-1:0];
            end
         end
         ST_DIV: begin
            div_en = 1'b1;
            cnt_d  = cnt_q + CW'(1);
            if (last_step) begin
               state_d    = ST_DONE;
               hi_we_d    = 1'b1;
               lo_we_d    = 1'b1;
               hi_wdata_d = rem_fixed;
               lo_wdata_d = quo_fixed;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // A flush abandons an in-flight op without touching HI/LO
      if (flush && (state_q != ST_IDLE)) begin
         state_d    = ST_IDLE;
         hi_we_d    = 1'b0;
         lo_we_d    = 1'b0;
         hi_wdata_d = hi_wdata_q;
         lo_wdata_d = lo_wdata_q;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         mcand_q    <= '0;
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         dz_q       <= 1'b0;
         hi_we_q    <= 1'b0;
         lo_we_q    <= 1'b0;
         hi_wdata_q <= '0;
         lo_wdata_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         mcand_q    <= mcand_d;
         neg_res_q  <= neg_res_d;
         neg_rem_q  <= neg_rem_d;
         dz_q       <= dz_d;
         hi_we_q    <= hi_we_d;
         lo_we_q    <= lo_we_d;
         hi_wdata_q <= hi_wdata_d;
         lo_wdata_q <= lo_wdata_d;
      end
   end

   mul_div_unit_div_iter #(.WIDTH(WIDTH)) u_div_iter (
      .clk           (clk),
      .rst           (rst),
      .load          (div_load),
      .en            (div_en),
      .dividend      (abs_a),
      .divisor       (abs_b),
      .quotient_nxt  (quo_nxt),
      .remainder_nxt (rem_nxt)
   );

   // Stall covers the accept cycle and every iteration cycle; DONE lets
   // the instruction leave EX. A flush during DONE suppresses the write.
   assign stallreq  = !rst && ((accept && is_iter_op(op)) ||
                               (state_q == ST_MUL) || (state_q == ST_DIV));
   assign busy      = (state_q != ST_IDLE);
   assign kill_done = flush && (state_q == ST_DONE);
   assign hi_we     = hi_we_q && !kill_done;
   assign lo_we     = lo_we_q && !kill_done;
   assign hi_wdata  = hi_wdata_q;
   assign lo_wdata  = lo_wdata_q;

endmodule
